// File: rtl/warp_rr_scheduler.sv
// Round-robin warp issue scheduler with per-warp pending-op budgets and a registered valid/ready issue port.
// Define WARP_SCHED_BARRIER_EN to build CTA-wide barrier holding.
module warp_rr_scheduler #(
    parameter int NUM_WARP     = 8,
    parameter int NUM_WARP_LOG = 3,
    parameter int PEND_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic [NUM_WARP-1:0]     run_mask_i,
    input  logic                    issue_ready_i,
    input  logic                    issue_long_i,
    input  logic                    bar_i,
    input  logic                    wb_valid_i,
    input  logic [NUM_WARP_LOG-1:0] wb_warp_i,
    output logic                    issue_valid_o,
    output logic [NUM_WARP_LOG-1:0] issue_warp_o,
    output logic                    idle_o,
    output logic                    err_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic                    issue_valid_q, issue_valid_d;
    logic [NUM_WARP_LOG-1:0] issue_warp_q, issue_warp_d;
    logic [NUM_WARP_LOG-1:0] rr_ptr_q, rr_ptr_d;
    logic                    err_q, err_d;
    logic [PEND_W-1:0]       pend_q [NUM_WARP];
    logic [PEND_W-1:0]       pend_d [NUM_WARP];
    logic [NUM_WARP-1:0]     bar_wait_d;

    logic                    accept;
    logic                    sel_en;
    logic [NUM_WARP_LOG-1:0] rr_base;
    logic [NUM_WARP-1:0]     inc_vec, dec_vec;
    logic [NUM_WARP-1:0]     eligible, busy;
    logic                    found;
    logic [NUM_WARP_LOG-1:0] winner;
    logic [NUM_WARP_LOG-1:0] idx;

    assign accept  = issue_valid_q & issue_ready_i & ~stall_i;
    assign sel_en  = ~stall_i & (~issue_valid_q | accept);
    // On accept the scan already starts after the warp being retired, not the stale pointer.
    assign rr_base = accept ? issue_warp_q : rr_ptr_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        inc_vec = '0;
        dec_vec = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            inc_vec[w] = accept & issue_long_i & (issue_warp_q == NUM_WARP_LOG'(w));
            dec_vec[w] = ~stall_i & wb_valid_i & (wb_warp_i == NUM_WARP_LOG'(w));
        end
    end

    always_comb begin
        err_d = err_q;
        for (int w = 0; w < NUM_WARP; w++) begin
            pend_d[w] = pend_q[w];
            if (inc_vec[w] && !dec_vec[w]) begin
                if (pend_q[w] == PEND_MAX) err_d = 1'b1;
                else                       pend_d[w] = pend_q[w] + 1'b1;
            end else if (dec_vec[w] && !inc_vec[w]) begin
                if (pend_q[w] == '0) err_d = 1'b1;
                else                 pend_d[w] = pend_q[w] - 1'b1;
            end
        end
    end

`ifdef WARP_SCHED_BARRIER_EN
    logic [NUM_WARP-1:0] bar_wait_q;
    logic                bar_release;

    assign bar_release = (&(bar_wait_q | ~run_mask_i)) & (|bar_wait_q);

    always_comb begin
        bar_wait_d = bar_wait_q;
        if (!stall_i) begin
            bar_wait_d = bar_release ? '0 : (bar_wait_q & run_mask_i);
            if (accept && bar_i) bar_wait_d[issue_warp_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) bar_wait_q <= '0;
        else       bar_wait_q <= bar_wait_d;
    end
`else
    logic unused_bar;
    assign unused_bar = bar_i;
    assign bar_wait_d = '0;
`endif

    // Next-cycle pending and barrier state gate eligibility so a warp never issues past its budget.
    always_comb begin
        eligible = '0;
        busy     = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            eligible[w] = run_mask_i[w] & (pend_d[w] != PEND_MAX) & ~bar_wait_d[w];
            busy[w]     = run_mask_i[w] & (pend_q[w] != '0);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= NUM_WARP; i++) begin
            idx = rr_base + NUM_WARP_LOG'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_warp_d  = issue_warp_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept) rr_ptr_d = issue_warp_q;
        if (sel_en) begin
            issue_valid_d = found;
            if (found) issue_warp_d = winner;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            rr_ptr_q      <= NUM_WARP_LOG'(NUM_WARP - 1);
            err_q         <= 1'b0;
            // NOTE: the counter array is reset because a stale budget would block a warp forever.
            for (int w = 0; w < NUM_WARP; w++) pend_q[w] <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            rr_ptr_q      <= rr_ptr_d;
            err_q         <= err_d;
            for (int w = 0; w < NUM_WARP; w++) pend_q[w] <= pend_d[w];
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_warp_o  = issue_warp_q;
    assign err_o         = err_q;
    assign idle_o        = ~issue_valid_q & ~(|busy);

endmodule

// File: tb/tb_warp_rr_scheduler.sv
// Self-checking bench for warp_rr_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_warp_rr_scheduler;

    localparam int NW   = 8;
    localparam int NL   = 3;
    localparam int PMAX = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_i;
    logic [NW-1:0] run_mask_i;
    logic          issue_ready_i;
    logic          issue_long_i;
    logic          bar_i;
    logic          wb_valid_i;
    logic [NL-1:0] wb_warp_i;
    logic          issue_valid_o;
    logic [NL-1:0] issue_warp_o;
    logic          idle_o;
    logic          err_o;

    always #5 clk = ~clk;

    warp_rr_scheduler #(.NUM_WARP(NW), .NUM_WARP_LOG(NL), .PEND_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .run_mask_i   (run_mask_i),
        .issue_ready_i(issue_ready_i),
        .issue_long_i (issue_long_i),
        .bar_i        (bar_i),
        .wb_valid_i   (wb_valid_i),
        .wb_warp_i    (wb_warp_i),
        .issue_valid_o(issue_valid_o),
        .issue_warp_o (issue_warp_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: pending counts, barrier waits, presented warp, last accepted warp.
    int m_pend [NW];
    bit m_bar  [NW];
    bit m_v;
    int m_w;
    int m_rr;
    bit m_err;
    bit m_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        for (int w = 0; w < NW; w++)
            if (run_mask_i[w] && m_pend[w] != 0) return 1'b0;
        return !m_v;
    endfunction

    task automatic model_step();
        int n [NW];
        bit nb [NW];
        bit acc, all_in, any_wait, fnd;
        int c;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin m_pend[w] = 0; m_bar[w] = 0; end
            m_v = 0; m_w = 0; m_rr = NW - 1; m_err = 0; m_rst = 1;
            return;
        end
        m_rst = 0;
        if (stall_i) return;
        acc = m_v && issue_ready_i;
        for (int w = 0; w < NW; w++) begin
            n[w] = m_pend[w];
            if (acc && issue_long_i && m_w == w) n[w] = n[w] + 1;
            if (wb_valid_i && int'(wb_warp_i) == w) n[w] = n[w] - 1;
            if (n[w] < 0)    begin n[w] = 0;    m_err = 1; end
            if (n[w] > PMAX) begin n[w] = PMAX; m_err = 1; end
        end
        all_in = 1; any_wait = 0;
        for (int w = 0; w < NW; w++) begin
            if (run_mask_i[w] && !m_bar[w]) all_in = 0;
            if (m_bar[w]) any_wait = 1;
        end
        for (int w = 0; w < NW; w++) nb[w] = 0;
`ifdef WARP_SCHED_BARRIER_EN
        for (int w = 0; w < NW; w++) nb[w] = (all_in && any_wait) ? 1'b0 : (m_bar[w] && run_mask_i[w]);
        if (acc && bar_i) nb[m_w] = 1;
`endif
        if (acc) m_rr = m_w;
        if (!m_v || acc) begin
            fnd = 0;
            for (int d = 1; d <= NW; d++) begin
                c = (m_rr + d) % NW;
                if (!fnd && run_mask_i[c] && n[c] < PMAX && !nb[c]) begin fnd = 1; m_w = c; end
            end
            m_v = fnd;
        end
        for (int w = 0; w < NW; w++) begin m_pend[w] = n[w]; m_bar[w] = nb[w]; end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("valid", issue_valid_o, m_v);
        if (m_v || m_rst) check("warp", issue_warp_o, m_w);
        check("err", err_o, m_err);
        check("idle", idle_o, model_idle());
    endtask

    task automatic drive(input bit st, input logic [NW-1:0] mask, input bit rdy, input bit lng,
                         input bit br, input bit wbv, input int wbw);
        stall_i = st; run_mask_i = mask; issue_ready_i = rdy; issue_long_i = lng;
        bar_i = br; wb_valid_i = wbv; wb_warp_i = NL'(wbw);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, '0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        do_reset();

        // Full mask: strict rotation 0..7 then wrap to 0.
        drive(0, 8'hFF, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            check("t1_valid", issue_valid_o, 1);
            check("t1_seq", issue_warp_o, i % NW);
        end

        // Back-pressure holds warp 2 stable, then 5, then 2.
        do_reset();
        drive(0, 8'b0010_0100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin step(); check("t2_hold", issue_warp_o, 2); end
        issue_ready_i = 1'b1;
        step(); check("t2_next5", issue_warp_o, 5);
        step(); check("t2_next2", issue_warp_o, 2);

        // Pending budget: 7 long ops exhaust warp 3, one writeback frees it.
        do_reset();
        drive(0, 8'h08, 1, 1, 0, 0, 0);
        step();
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t3_budget", issue_valid_o, (i < 7) ? 1 : 0);
        end
        drive(0, 8'h08, 1, 0, 0, 1, 3);
        step(); check("t3_resume", issue_valid_o, 1); check("t3_warp", issue_warp_o, 3);
        wb_valid_i = 1'b0;
        step();

        // Simultaneous inc/dec is neutral; decrement at zero sets sticky error.
        do_reset();
        drive(0, 8'h10, 1, 1, 0, 0, 0);
        step(); step(); step();
        wb_valid_i = 1'b1; wb_warp_i = 3'd4;
        step(); check("t4_incdec_err", err_o, 0);
        drive(0, 8'h10, 0, 0, 0, 1, 6);
        step(); check("t4_err_set", err_o, 1);
        wb_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); check("t4_err_sticky", err_o, 1); end

        // Stall freezes everything; reset drops the presented warp.
        do_reset();
        drive(0, 8'hFF, 1, 1, 0, 0, 0);
        step(); step(); step();
        check("t5_pre", issue_warp_o, 2);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin step(); check("t5_frozen", issue_warp_o, 2); end
        stall_i = 1'b0;
        step(); check("t5_after", issue_warp_o, 3);
        reset = 1'b1;
        step(); check("t5_rst_valid", issue_valid_o, 0);
        reset = 1'b0;
        step(); check("t5_first", issue_warp_o, 0);

`ifdef WARP_SCHED_BARRIER_EN
        // All four running warps arrive at the barrier, release, resume at warp 0.
        do_reset();
        drive(0, 8'h0F, 1, 0, 1, 0, 0);
        step();
        for (int i = 0; i < 4; i++) step();
        check("t6_blocked", issue_valid_o, 0);
        bar_i = 1'b0;
        step(); check("t6_release", issue_valid_o, 1); check("t6_resume", issue_warp_o, 0);
`endif

        // Random traffic against the model.
        do_reset();
        run_mask_i = 8'hFF;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall_i       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) run_mask_i = NW'($urandom);
            issue_ready_i = ($urandom_range(0, 9) < 7);
            issue_long_i  = ($urandom_range(0, 9) < 4);
            bar_i         = ($urandom_range(0, 9) == 0);
            wb_valid_i    = 1'b0;
            wb_warp_i     = NL'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, NW - 1);
                for (int j = 0; j < NW; j++)
                    if (!wb_valid_i && m_pend[(k + j) % NW] > 0) begin
                        wb_valid_i = 1'b1;
                        wb_warp_i  = NL'((k + j) % NW);
                    end
            end
            if ($urandom_range(0, 99) == 0) wb_valid_i = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
